// File: rtl/serial_adder_sub_if.sv
// Bundles the operation request and result signals of serial_adder_sub.
// master = requester, slave = the serial adder/subtractor.
interface serial_adder_sub_if #(
  parameter int WIDTH = 8
);
  // Handshake: start is a request that is accepted on a rising edge only
  // while the block is idle (busy=0 and done=0); sub/a/b/c_in are sampled on
  // that same edge and never again until the next accepted start. done is a
  // one-cycle valid pulse for sum/c_out/overflow, which then hold their value.
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/serial_adder_sub.sv
// Bit-serial add/subtract: one full-add per clock, LSB first, result published
// in a single update when the last bit is done.
module serial_adder_sub #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_sub_if.slave   bus,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic             bit_s;
  logic             bit_c;
  logic [CW-1:0]    cnt;

  assign dbg_state = state;

  always_comb begin
    bit_s   = a_sh[0] ^ b_sh[0] ^ carry;
    bit_c   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    // Partial result shifts in from the top so the MSB lands last.
    res_nxt = res_sh >> 1;
    res_nxt[WIDTH-1] = bit_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_sh         <= '0;
      b_sh         <= '0;
      res_sh       <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.sum      <= '0;
      bus.c_out    <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Subtract is a + ~b + ~c_in, i.e. a - b - c_in.
            a_sh     <= bus.a;
            b_sh     <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.c_in ^ bus.sub;
            res_sh   <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= bit_c;
          res_sh <= res_nxt;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB on this edge.
            bus.sum      <= res_nxt;
            bus.c_out    <= bit_c;
            bus.overflow <= carry ^ bit_c;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_sub.sv
// Bench for serial_adder_sub: 8-bit directed/random checks plus exhaustive
// sweeps of 4-bit and 1-bit builds against an arithmetic reference model.
module tb_serial_adder_sub;

  logic clk;
  logic rst_n;
  logic [1:0] st8, st4, st1;

  int tests;
  int failed;

  serial_adder_sub_if #(.WIDTH(8)) b8 ();
  serial_adder_sub_if #(.WIDTH(4)) b4 ();
  serial_adder_sub_if #(.WIDTH(1)) b1 ();

  serial_adder_sub #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8), .dbg_state(st8));
  serial_adder_sub #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4), .dbg_state(st4));
  serial_adder_sub #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1), .dbg_state(st1));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input int w, input logic s, input longint av, input longint bv,
                                input logic ci, output longint rs, output logic rc, output logic ro);
    longint m, half, u, sa, sb, r;
    m    = longint'(1) << w;
    half = m >> 1;
    u    = s ? (av - bv - longint'(ci)) : (av + bv + longint'(ci));
    rs   = u & (m - 1);
    rc   = s ? (u >= 0) : (u >= m);
    sa   = (av >= half) ? av - m : av;
    sb   = (bv >= half) ? bv - m : bv;
    r    = s ? (sa - sb - longint'(ci)) : (sa + sb + longint'(ci));
    ro   = (r < -half) || (r > half - 1);
  endfunction

  // ---------------- drivers ----------------
  task automatic do_op8(input logic s, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                        output logic [7:0] rs, output logic rc, output logic ro, output int lat);
    b8.sub = s; b8.a = av; b8.b = bv; b8.c_in = ci; b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    chk("busy_after_start", b8.busy, 1);
    for (lat = 1; lat <= 40; lat++) begin
      @(posedge clk); #1;
      if (b8.done) break;
      chk("busy_during_run", b8.busy, 1);
    end
    chk("busy_at_done", b8.busy, 0);
    rs = b8.sum; rc = b8.c_out; ro = b8.overflow;
    @(posedge clk); #1;
    chk("done_one_cycle", b8.done, 0);
  endtask

  task automatic do_op4(input logic s, input logic [3:0] av, input logic [3:0] bv, input logic ci,
                        output logic [3:0] rs, output logic rc, output logic ro);
    int n;
    b4.sub = s; b4.a = av; b4.b = bv; b4.c_in = ci; b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (b4.done) break;
    end
    chk("w4_latency", n, 4);
    rs = b4.sum; rc = b4.c_out; ro = b4.overflow;
    @(posedge clk); #1;
  endtask

  task automatic do_op1(input logic s, input logic av, input logic bv, input logic ci,
                        output logic rs, output logic rc, output logic ro);
    int n;
    b1.sub = s; b1.a = av; b1.b = bv; b1.c_in = ci; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (b1.done) break;
    end
    chk("w1_latency", n, 1);
    rs = b1.sum; rc = b1.c_out; ro = b1.overflow;
    @(posedge clk); #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       s;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [7:0] rs8;
    logic [3:0] rs4;
    logic       rs1, rc, ro;
    longint     ms;
    logic       mc, mo;
    int         lat, nd, cyc;
    int         t[3];
    logic [7:0] ra, rb;
    logic       rsub, rci;

    tests = 0; failed = 0;
    vt[0] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vt[1] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vt[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    vt[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vt[5] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[6] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0};
    vt[7] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[8] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    b8.start = 0; b8.sub = 0; b8.a = '0; b8.b = '0; b8.c_in = 0;
    b4.start = 0; b4.sub = 0; b4.a = '0; b4.b = '0; b4.c_in = 0;
    b1.start = 0; b1.sub = 0; b1.a = '0; b1.b = '0; b1.c_in = 0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", b8.busy, 0);
    chk("rst_done", b8.done, 0);
    chk("rst_sum", b8.sum, 0);
    chk("rst_cout", b8.c_out, 0);
    chk("rst_ovf", b8.overflow, 0);
    chk("rst_state", st8, 0);
    chk("rst_w4_sum", b4.sum, 0);
    chk("rst_w1_busy", b1.busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of hand-computed vectors
    for (int i = 0; i < 9; i++) begin
      do_op8(vt[i].s, vt[i].a, vt[i].b, vt[i].ci, rs8, rc, ro, lat);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_sum", i), rs8, vt[i].es);
      chk($sformatf("vec%0d_cout", i), rc, vt[i].ec);
      chk($sformatf("vec%0d_ovf", i), ro, vt[i].eo);
    end

    // start asserted during RUN and during DONE is ignored
    b8.sub = 0; b8.a = 8'h0F; b8.b = 8'h01; b8.c_in = 0; b8.start = 1;
    @(posedge clk); #1;
    b8.sub = 1; b8.a = 8'hAA; b8.b = 8'h55; b8.c_in = 1;
    for (lat = 1; lat <= 40; lat++) begin
      @(posedge clk); #1;
      if (lat == 3) b8.start = 0;
      if (b8.done) break;
    end
    chk("ign_latency", lat, 8);
    chk("ign_sum", b8.sum, 8'h10);
    chk("ign_cout", b8.c_out, 0);
    chk("ign_ovf", b8.overflow, 0);
    b8.start = 1; b8.a = 8'h33; b8.b = 8'h44;
    @(posedge clk); #1;
    b8.start = 0;
    chk("ign_done_busy", b8.busy, 0);
    chk("ign_done_state", st8, 0);
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (b8.done) nd++;
    end
    chk("ign_no_extra_done", nd, 0);
    chk("ign_sum_held", b8.sum, 8'h10);

    // start held high: back-to-back operations every WIDTH+2 cycles
    b8.sub = 0; b8.a = 8'h11; b8.b = 8'h22; b8.c_in = 0; b8.start = 1;
    nd = 0;
    for (cyc = 0; cyc < 40 && nd < 3; cyc++) begin
      @(posedge clk); #1;
      if (b8.done) begin
        t[nd] = cyc;
        nd++;
      end
    end
    b8.start = 0;
    chk("b2b_count", nd, 3);
    chk("b2b_gap1", t[1] - t[0], 10);
    chk("b2b_gap2", t[2] - t[1], 10);
    chk("b2b_sum", b8.sum, 8'h33);
    repeat (12) @(posedge clk);
    #1;

    // Reset on the 4th RUN cycle aborts the operation; start under reset ignored
    b8.sub = 0; b8.a = 8'h01; b8.b = 8'h02; b8.c_in = 0; b8.start = 1;
    @(posedge clk); #1;
    b8.start = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0; b8.start = 1;
    @(posedge clk); #1;
    chk("abort_busy", b8.busy, 0);
    chk("abort_done", b8.done, 0);
    chk("abort_sum", b8.sum, 0);
    chk("abort_state", st8, 0);
    rst_n = 1; b8.start = 0;
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (b8.done) nd++;
    end
    chk("abort_no_done", nd, 0);
    do_op8(1'b0, 8'h01, 8'h02, 1'b0, rs8, rc, ro, lat);
    chk("after_abort_sum", rs8, 8'h03);
    chk("after_abort_latency", lat, 8);

    // Randomized 8-bit operations vs reference model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rsub = 1'($urandom_range(0, 1));
      rci  = 1'($urandom_range(0, 1));
      do_op8(rsub, ra, rb, rci, rs8, rc, ro, lat);
      model(8, rsub, longint'(ra), longint'(rb), rci, ms, mc, mo);
      chk("rnd_sum", rs8, ms);
      chk("rnd_cout", rc, mc);
      chk("rnd_ovf", ro, mo);
    end

    // Exhaustive WIDTH=4 sweep
    for (int s = 0; s < 2; s++)
      for (int ci = 0; ci < 2; ci++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++) begin
            do_op4(1'(s), 4'(a), 4'(b), 1'(ci), rs4, rc, ro);
            model(4, 1'(s), longint'(a), longint'(b), 1'(ci), ms, mc, mo);
            chk("w4_sum", rs4, ms);
            chk("w4_cout", rc, mc);
            chk("w4_ovf", ro, mo);
          end

    // Exhaustive WIDTH=1 sweep
    for (int s = 0; s < 2; s++)
      for (int ci = 0; ci < 2; ci++)
        for (int a = 0; a < 2; a++)
          for (int b = 0; b < 2; b++) begin
            do_op1(1'(s), 1'(a), 1'(b), 1'(ci), rs1, rc, ro);
            model(1, 1'(s), longint'(a), longint'(b), 1'(ci), ms, mc, mo);
            chk("w1_sum", rs1, ms);
            chk("w1_cout", rc, mc);
            chk("w1_ovf", ro, mo);
          end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/serial_adder_sub.md
SERIAL_ADDER_SUB -- requirements
Module: serial_adder_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range WIDTH >= 1).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port sub  input  1  mode select: 0 = add, 1 = subtract.
REQ-006 SHALL have port a  input  WIDTH  first operand.
REQ-007 SHALL have port b  input  WIDTH  second operand.
REQ-008 SHALL have port c_in  input  1  carry-in (add) or borrow-in (subtract).
REQ-009 SHALL have port busy  output  1  high while bits are being processed.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-011 SHALL have port sum  output  WIDTH  result word.
REQ-012 SHALL have port c_out  output  1  carry-out of the MSB (subtract: 1 = no borrow).
REQ-013 SHALL have port overflow  output  1  two's-complement signed overflow.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-015 In IDLE, start=1 at edge k SHALL capture a, b, sub and c_in and move to RUN; inputs SHALL NOT be sampled again until the next accepted start.
REQ-016 Captured operand SHALL be b when sub=0 and ~b when sub=1; initial carry SHALL be c_in when sub=0 and ~c_in when sub=1, so subtract yields a - b - c_in.
REQ-017 In RUN, one 1-bit full-add per cycle, LSB first: bit i SHALL be computed at edge k+1+i as sum_i = a_i ^ b'_i ^ carry, carry <= majority(a_i, b'_i, carry).
REQ-018 After the MSB edge (k+WIDTH) the FSM SHALL enter DONE; busy SHALL be high from after edge k through edge k+WIDTH, then low.
REQ-019 sum, c_out and overflow SHALL update only on the edge entering DONE and SHALL hold their value until the next DONE entry or reset; partial results SHALL NOT be visible on sum.
REQ-020 overflow SHALL equal carry into the MSB XOR carry out of the MSB.
REQ-021 done SHALL be high for exactly the one cycle spent in DONE, after which the FSM SHALL return to IDLE unconditionally.
REQ-022 start SHALL be ignored in RUN and DONE; minimum spacing between accepted starts is WIDTH+2 cycles; start held high SHALL produce back-to-back operations at that rate.
REQ-023 With WIDTH=1 the block SHALL behave as a registered single full adder/subtractor with one RUN cycle.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force IDLE and clear busy, done, sum, c_out, overflow and all internal shift/carry state to 0.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no done pulse; start sampled while rst_n=0 SHALL be ignored.
REQ-026 The first start accepted after rst_n returns high SHALL operate normally.

Verification (WIDTH=8 unless stated)
REQ-027 Add a=0x0F, b=0x01, c_in=0, start at edge k -> busy high for 8 cycles, done pulses in the cycle after edge k+8, sum=0x10, c_out=0, overflow=0.
REQ-028 Add a=0xFF, b=0x01, c_in=1 -> sum=0x01, c_out=1, overflow=0; add a=0x7F, b=0x01, c_in=0 -> sum=0x80, c_out=0, overflow=1.
REQ-029 Subtract a=0x05, b=0x07, c_in=0 -> sum=0xFE, c_out=0, overflow=0; subtract a=0x80, b=0x01, c_in=0 -> sum=0x7F, c_out=1, overflow=1.
REQ-030 Start pulsed again with different operands during RUN and in DONE -> ignored, first result unchanged; start held high -> done pulses every 10 cycles.
REQ-031 rst_n low for one edge at the 4th RUN cycle -> next cycle busy=0, done=0, sum=0, no done pulse for the aborted op; new start then completes correctly.
REQ-032 WIDTH=4 and WIDTH=1 builds: exhaustive sweep of a, b, c_in, sub against a reference model of a +/- b +/- c_in -> all sum, c_out and overflow match.
